// File: rtl/ib_pkg.sv
// Shared types and constants for the instruction-buffer fetch block.
package ib_pkg;

  localparam int unsigned DEF_AWIDTH = 6;
  localparam int unsigned DEF_DWIDTH = 32;

  localparam logic [31:0] HALT_WORD = 32'hFFFF_FFFF;

  typedef enum logic [1:0] {
    StIdle,
    StFetch,
    StHalt
  } fetch_state_t;

endpackage

// File: rtl/ib_fetch_ctrl.sv
// Fetch state machine plus load/branch/stop decode for ib_fetch_pc.
// IB_FETCH_WRAP_TRAP_EN adds the sticky wrap_err trap on a load from the top address.
module ib_fetch_ctrl
  import ib_pkg::*;
(
  input  logic clk_i,
  input  logic rst_i,
  input  logic start_i,
  input  logic branch_valid_i,
  input  logic instr_valid_i,
  input  logic instr_ready_i,
  input  logic is_halt_word_i,
`ifdef IB_FETCH_WRAP_TRAP_EN
  input  logic pc_max_i,
  output logic wrap_err_o,
`endif
  output logic branch_o,
  output logic load_o,
  output logic adv_o,
  output logic drop_o,
  output logic halted_o
);

  fetch_state_t state_q;
  logic         in_fetch;
  logic         wrap_hit;
  logic         stop;

  assign in_fetch = (state_q == StFetch);
  assign branch_o = in_fetch && branch_valid_i;
  // Branch beats both load and stall.
  assign load_o   = in_fetch && !branch_valid_i && (!instr_valid_i || instr_ready_i);

`ifdef IB_FETCH_WRAP_TRAP_EN
  assign wrap_hit = load_o && pc_max_i;
`else
  assign wrap_hit = 1'b0;
`endif

  assign stop   = load_o && (is_halt_word_i || wrap_hit);
  assign adv_o  = load_o && !stop;
  // In HALT the last word is still presented until decode takes it.
  assign drop_o = (state_q == StHalt) && instr_valid_i && instr_ready_i;

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q    <= StIdle;
      halted_o   <= 1'b0;
`ifdef IB_FETCH_WRAP_TRAP_EN
      wrap_err_o <= 1'b0;
`endif
    end else begin
      unique case (state_q)
        StIdle: begin
          if (start_i) state_q <= StFetch;
        end
        StFetch: begin
          if (stop) begin
            state_q  <= StHalt;
            halted_o <= 1'b1;
          end
`ifdef IB_FETCH_WRAP_TRAP_EN
          if (wrap_hit) wrap_err_o <= 1'b1;
`endif
        end
        StHalt: ;
        default: state_q <= StIdle;
      endcase
    end
  end

endmodule

// File: rtl/ib_fetch_pc.sv
// Fetch PC and instruction register feeding decode; incrementer lives outside (pc -> pc_next).
// IB_FETCH_WRAP_TRAP_EN adds output wrap_err and halts on a load from the all-ones address.
module ib_fetch_pc
  import ib_pkg::*;
#(
  parameter int unsigned AWIDTH = DEF_AWIDTH,
  parameter int unsigned DWIDTH = DEF_DWIDTH
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  output logic [AWIDTH-1:0] pc,
  input  logic [AWIDTH-1:0] pc_next,
  input  logic [DWIDTH-1:0] instr_in,
  input  logic              branch_valid,
  input  logic [AWIDTH-1:0] branch_addr,
  output logic [DWIDTH-1:0] instr_out,
  output logic [AWIDTH-1:0] instr_pc,
  output logic              instr_valid,
  input  logic              instr_ready,
  output logic              halted
`ifdef IB_FETCH_WRAP_TRAP_EN
  ,
  output logic              wrap_err
`endif
);

  localparam logic [DWIDTH-1:0] HaltWord = DWIDTH'(HALT_WORD);

  logic branch;
  logic load;
  logic adv;
  logic drop;

  ib_fetch_ctrl u_ctrl (
    .clk_i          (clk),
    .rst_i          (rst),
    .start_i        (start),
    .branch_valid_i (branch_valid),
    .instr_valid_i  (instr_valid),
    .instr_ready_i  (instr_ready),
    .is_halt_word_i (instr_in == HaltWord),
`ifdef IB_FETCH_WRAP_TRAP_EN
    .pc_max_i       (&pc),
    .wrap_err_o     (wrap_err),
`endif
    .branch_o       (branch),
    .load_o         (load),
    .adv_o          (adv),
    .drop_o         (drop),
    .halted_o       (halted)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      pc          <= '0;
      instr_out   <= '0;
      instr_pc    <= '0;
      instr_valid <= 1'b0;
    end else if (branch) begin
      pc          <= branch_addr;
      instr_valid <= 1'b0;
    end else if (load) begin
      instr_out   <= instr_in;
      instr_pc    <= pc;
      instr_valid <= 1'b1;
      if (adv) pc <= pc_next;
    end else if (drop) begin
      instr_valid <= 1'b0;
    end
  end

endmodule

// File: doc/ib_fetch_pc.md
IB_FETCH_PC -- requirements
Module: ib_fetch_pc

Interface
REQ-001 SHALL have parameter AWIDTH, default 6, instruction-buffer address width.
REQ-002 SHALL have parameter DWIDTH, default 32, instruction word width.
REQ-003 SHALL have port clk  input  1  sole clock, all state on rising edge.
REQ-004 SHALL have port rst  input  1  reset, asynchronous, active-high.
REQ-005 SHALL have port start  input  1  one-cycle pulse, begins fetching from IDLE.
REQ-006 SHALL have port pc  output  AWIDTH  current fetch address, driven to the buffer read port and to the incrementer addr input.
REQ-007 SHALL have port pc_next  input  AWIDTH  incremented address returned by the incrementer (addr_out).
REQ-008 SHALL have port instr_in  input  DWIDTH  buffer read data for pc, combinational same-cycle.
REQ-009 SHALL have port branch_valid  input  1  redirect request.
REQ-010 SHALL have port branch_addr  input  AWIDTH  redirect target.
REQ-011 SHALL have port instr_out  output  DWIDTH  registered instruction to decode.
REQ-012 SHALL have port instr_pc  output  AWIDTH  address instr_out was fetched from.
REQ-013 SHALL have port instr_valid  output  1  instr_out holds a valid word.
REQ-014 SHALL have port instr_ready  input  1  decode accepts instr_out this cycle.
REQ-015 SHALL have port halted  output  1  block is in HALT.

Function
REQ-016 SHALL implement states IDLE, FETCH, HALT.
REQ-017 IDLE: pc held at 0, instr_valid 0; start -> FETCH next cycle.
REQ-018 FETCH: load condition = !instr_valid || instr_ready; on load, instr_out<=instr_in, instr_pc<=pc, instr_valid<=1, pc<=pc_next.
REQ-019 FETCH without load (valid && !ready): pc, instr_out, instr_pc, instr_valid all held (stall).
REQ-020 Latency: word at pc visible on instr_out exactly one cycle after the load edge; throughput one word/cycle with instr_ready held 1.
REQ-021 Transfer occurs on any edge where instr_valid && instr_ready; word is consumed exactly once.
REQ-022 branch_valid in FETCH SHALL take priority over load and stall: pc<=branch_addr, instr_valid<=0 (in-flight word dropped), no capture that cycle.
REQ-023 branch_valid in IDLE or HALT SHALL be ignored.
REQ-024 Captured word equal to HALT_WORD SHALL be presented normally (instr_valid 1) and state -> HALT in the same edge; pc not advanced.
REQ-025 HALT: no further loads; instr_out holds until accepted, then instr_valid 0; halted=1; exit only by reset.
REQ-026 start while in FETCH or HALT SHALL be ignored.
REQ-027 pc arithmetic is AWIDTH-bit modulo; increment comes only from pc_next, never computed internally.

Reset
REQ-028 rst asserted SHALL immediately force state IDLE, pc=0, instr_out=0, instr_pc=0, instr_valid=0, halted=0 (and wrap_err=0), including mid-stall or mid-branch.
REQ-029 First active edge after rst deasserts SHALL evaluate start normally.

Configuration
REQ-030 Macro IB_FETCH_WRAP_TRAP_EN defined: output wrap_err (1 bit) added; a load with pc == all-ones SHALL capture the word, set wrap_err=1, enter HALT; wrap_err sticky until reset.
REQ-031 Macro undefined: no wrap_err port; pc wraps all-ones -> 0 silently and fetching continues.

Structure
REQ-032 Shared package ib_pkg SHALL hold the state enum type (fetch_state_t), HALT_WORD (32'hFFFF_FFFF) and default AWIDTH/DWIDTH constants.
REQ-033 One sub-module ib_fetch_ctrl (state machine + load/branch decode) is natural; datapath registers stay in ib_fetch_pc. The incrementer remains external, connected with inc tied to 1.

Verification
REQ-034 rst, start, instr_ready=1, buffer word[i]=i -> pc 0,1,2,...; instr_out 0,1,2 with instr_pc matching, first valid one cycle after start+1 edge.
REQ-035 instr_ready=0 for 3 cycles while instr_out=5 -> instr_out/instr_pc/pc frozen, then word 5 accepted once, word 6 next.
REQ-036 branch_valid with branch_addr=20 while instr_out=7 valid -> next cycle instr_valid=0, pc=20; following cycle instr_out=word[20].
REQ-037 word[9]=HALT_WORD -> instr_out=HALT_WORD presented, halted=1, pc stays 9, no later valid words; start ignored.
REQ-038 Run to pc=63: with IB_FETCH_WRAP_TRAP_EN wrap_err=1, halted=1; without, next instr_pc=0.
REQ-039 Assert rst during stall at pc=12 -> outputs zero immediately, IDLE; start restarts at pc=0.
